// File: rtl/aes_round_ops.sv
// AES round primitives: AddRoundKey, ShiftRows and MixColumns as three independent
// single-cycle registered engines. Define AES_ROUND_INV_EN to add the inv port and inverse transforms.
module aes_round_ops (
  input  logic         clk,
  input  logic         rst,
`ifdef AES_ROUND_INV_EN
  input  logic         inv,
`endif
  input  logic         ark_en,
  input  logic [127:0] ark_state,
  input  logic [127:0] ark_key,
  output logic [127:0] ark_out,
  output logic         ark_done,
  input  logic         sr_en,
  input  logic [127:0] sr_in,
  output logic [127:0] sr_out,
  output logic         sr_done,
  input  logic         mc_en,
  input  logic [127:0] mc_in,
  output logic [127:0] mc_out,
  output logic         mc_done
);

  // GF(2^8) doubling with the AES reduction polynomial
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixColFwd(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    logic [7:0] d0, d1, d2, d3;
    s0 = col[31:24];
    s1 = col[23:16];
    s2 = col[15:8];
    s3 = col[7:0];
    d0 = xtime(s0);
    d1 = xtime(s1);
    d2 = xtime(s2);
    d3 = xtime(s3);
    return {d0 ^ (d1 ^ s1) ^ s2 ^ s3,
            s0 ^ d1 ^ (d2 ^ s2) ^ s3,
            s0 ^ s1 ^ d2 ^ (d3 ^ s3),
            (d0 ^ s0) ^ s1 ^ s2 ^ d3};
  endfunction

  // Byte 4c+r of the result takes row r from column (c+r) mod 4
  function automatic logic [127:0] shiftRowsFwd(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mixColumnsFwd(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[127-32*c -: 32] = mixColFwd(s[127-32*c -: 32]);
    end
    return r;
  endfunction

`ifdef AES_ROUND_INV_EN
  // Inverse matrix coefficients 09/0b/0d/0e built from shared doubling chains
  function automatic logic [31:0] mixColInv(input logic [31:0] col);
    logic [7:0] s [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    s[0] = col[31:24];
    s[1] = col[23:16];
    s[2] = col[15:8];
    s[3] = col[7:0];
    for (int i = 0; i < 4; i++) begin
      x2    = xtime(s[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ s[i];
      mb[i] = x8 ^ x2 ^ s[i];
      md[i] = x8 ^ x4 ^ s[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] shiftRowsInv(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c-row+4)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mixColumnsInv(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[127-32*c -: 32] = mixColInv(s[127-32*c -: 32]);
    end
    return r;
  endfunction
`endif

  logic [127:0] arkOut_d, arkOut_q;
  logic [127:0] srOut_d, srOut_q;
  logic [127:0] mcOut_d, mcOut_q;
  logic         arkDone_q, srDone_q, mcDone_q;

  // Next results are pure combinational functions of the current inputs
  always_comb begin
    arkOut_d = ark_state ^ ark_key;
`ifdef AES_ROUND_INV_EN
    srOut_d  = inv ? shiftRowsInv(sr_in) : shiftRowsFwd(sr_in);
    mcOut_d  = inv ? mixColumnsInv(mc_in) : mixColumnsFwd(mc_in);
`else
    srOut_d  = shiftRowsFwd(sr_in);
    mcOut_d  = mixColumnsFwd(mc_in);
`endif
  end

  // Each engine captures on enable and holds its last result otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      arkOut_q  <= '0;
      arkDone_q <= 1'b0;
    end else begin
      arkDone_q <= ark_en;
      if (ark_en) arkOut_q <= arkOut_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      srOut_q  <= '0;
      srDone_q <= 1'b0;
    end else begin
      srDone_q <= sr_en;
      if (sr_en) srOut_q <= srOut_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcOut_q  <= '0;
      mcDone_q <= 1'b0;
    end else begin
      mcDone_q <= mc_en;
      if (mc_en) mcOut_q <= mcOut_d;
    end
  end

  assign ark_out  = arkOut_q;
  assign ark_done = arkDone_q;
  assign sr_out   = srOut_q;
  assign sr_done  = srDone_q;
  assign mc_out   = mcOut_q;
  assign mc_done  = mcDone_q;

endmodule

// File: tb/tb_aes_round_ops.sv
// Scoreboard bench for aes_round_ops: a byte-level reference model pushes expected
// outputs per driven cycle; they are popped and asserted one cycle later.
module tb_aes_round_ops;

  logic         clk = 1'b0;
  logic         rst;
  logic         ark_en, sr_en, mc_en;
  logic [127:0] ark_state, ark_key, sr_in, mc_in;
  logic [127:0] ark_out, sr_out, mc_out;
  logic         ark_done, sr_done, mc_done;
  logic         invSel = 1'b0;
`ifdef AES_ROUND_INV_EN
  logic         inv;
  assign inv = invSel;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    string        tag;
    logic [127:0] ark;
    logic         arkDone;
    logic [127:0] sr;
    logic         srDone;
    logic [127:0] mc;
    logic         mcDone;
  } expT;

  expT sb[$];
  logic [127:0] mArk, mSr, mMc;
  logic         mArkDone, mSrDone, mMcDone;

  aes_round_ops dut (
    .clk       (clk),
    .rst       (rst),
`ifdef AES_ROUND_INV_EN
    .inv       (inv),
`endif
    .ark_en    (ark_en),
    .ark_state (ark_state),
    .ark_key   (ark_key),
    .ark_out   (ark_out),
    .ark_done  (ark_done),
    .sr_en     (sr_en),
    .sr_in     (sr_in),
    .sr_out    (sr_out),
    .sr_done   (sr_done),
    .mc_en     (mc_en),
    .mc_in     (mc_in),
    .mc_out    (mc_out),
    .mc_done   (mc_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Generic shift-and-add field multiply
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] refShift(input logic [127:0] s, input logic invMode);
    logic [7:0] b [16];
    logic [127:0] r = '0;
    int src;
    for (int n = 0; n < 16; n++) b[n] = s[127-8*n -: 8];
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        src = invMode ? (c + 4 - row) % 4 : (c + row) % 4;
        r[127-8*(4*c+row) -: 8] = b[4*src+row];
      end
    return r;
  endfunction

  function automatic logic [127:0] refMix(input logic [127:0] s, input logic invMode);
    logic [7:0] k [4];
    logic [7:0] b [16];
    logic [7:0] acc;
    logic [127:0] r = '0;
    if (invMode) begin k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09; end
    else         begin k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01; end
    for (int n = 0; n < 16; n++) b[n] = s[127-8*n -: 8];
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gmul(k[(j - row + 4) % 4], b[4*c+j]);
        r[127-8*(4*c+row) -: 8] = acc;
      end
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic checkOutput();
    expT e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty observed=0 entries expected>=1");
      return;
    end
    e = sb.pop_front();
    checkVal({e.tag, ".ark_out"},  ark_out,  e.ark);
    checkVal({e.tag, ".ark_done"}, {127'd0, ark_done}, {127'd0, e.arkDone});
    checkVal({e.tag, ".sr_out"},   sr_out,   e.sr);
    checkVal({e.tag, ".sr_done"},  {127'd0, sr_done},  {127'd0, e.srDone});
    checkVal({e.tag, ".mc_out"},   mc_out,   e.mc);
    checkVal({e.tag, ".mc_done"},  {127'd0, mc_done},  {127'd0, e.mcDone});
  endtask

  // Inputs are already driven (at a negedge); model the coming posedge, then check
  task automatic applyStimulus(input string tag);
    expT e;
    if (rst) begin
      mArk = '0; mSr = '0; mMc = '0;
      mArkDone = 1'b0; mSrDone = 1'b0; mMcDone = 1'b0;
    end else begin
      mArkDone = ark_en;
      mSrDone  = sr_en;
      mMcDone  = mc_en;
      if (ark_en) mArk = ark_state ^ ark_key;
      if (sr_en)  mSr  = refShift(sr_in, invSel);
      if (mc_en)  mMc  = refMix(mc_in, invSel);
    end
    e.tag = tag;
    e.ark = mArk; e.arkDone = mArkDone;
    e.sr  = mSr;  e.srDone  = mSrDone;
    e.mc  = mMc;  e.mcDone  = mMcDone;
    sb.push_back(e);
    @(negedge clk);
    checkOutput();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    rst = 1'b1;
    ark_en = 1'b1; sr_en = 1'b1; mc_en = 1'b1;
    ark_state = rnd128(); ark_key = rnd128(); sr_in = rnd128(); mc_in = rnd128();
    applyStimulus("reset");

    rst = 1'b0; sr_en = 1'b0; mc_en = 1'b0;
    ark_state = 128'h3243f6a8885a308d313198a2e0370734;
    ark_key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    applyStimulus("ark_vec");
    checkVal("ark_vec.const", ark_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

    ark_en = 1'b0; sr_en = 1'b1;
    sr_in = 128'h000102030405060708090a0b0c0d0e0f;
    applyStimulus("sr_vec");
    checkVal("sr_vec.const", sr_out, 128'h00050a0f04090e03080d02070c01060b);

    sr_en = 1'b0; mc_en = 1'b1;
    mc_in = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    applyStimulus("mc_vec");
    checkVal("mc_vec.const", mc_out, 128'h046681e5e0cb199a48f8d37a2806264c);

    mc_en = 1'b0;
    applyStimulus("all_idle");

    ark_en = 1'b1; sr_en = 1'b1; mc_en = 1'b1;
    ark_state = rnd128(); ark_key = rnd128(); sr_in = rnd128(); mc_in = rnd128();
    applyStimulus("all_on");

    ark_en = 1'b0; mc_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sr_in = rnd128();
      applyStimulus($sformatf("sr_hold%0d", i));
    end
    sr_en = 1'b0;
    sr_in = rnd128();
    applyStimulus("sr_drop");
    applyStimulus("sr_drop2");

    for (int i = 0; i < 20; i++) begin
      ark_en = 1'($urandom_range(0, 1));
      sr_en  = 1'($urandom_range(0, 1));
      mc_en  = 1'($urandom_range(0, 1));
      ark_state = rnd128(); ark_key = rnd128(); sr_in = rnd128(); mc_in = rnd128();
      if (i == 7) mc_in = '1;
      if (i == 8) mc_in = {16{8'h80}};
      applyStimulus($sformatf("rand%0d", i));
    end

    ark_en = 1'b1; sr_en = 1'b1; mc_en = 1'b1;
    ark_state = rnd128(); ark_key = rnd128(); sr_in = rnd128(); mc_in = rnd128();
    applyStimulus("pre_reset");
    rst = 1'b1;
    applyStimulus("mid_reset");
    rst = 1'b0;
    ark_state = rnd128(); ark_key = rnd128(); sr_in = rnd128(); mc_in = rnd128();
    applyStimulus("post_reset");

`ifdef AES_ROUND_INV_EN
    invSel = 1'b1;
    ark_en = 1'b0; sr_en = 1'b1; mc_en = 1'b1;
    mc_in = 128'h046681e5e0cb199a48f8d37a2806264c;
    sr_in = 128'h00050a0f04090e03080d02070c01060b;
    applyStimulus("inv_vec");
    checkVal("inv_mc.const", mc_out, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    checkVal("inv_sr.const", sr_out, 128'h000102030405060708090a0b0c0d0e0f);
    ark_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ark_state = rnd128(); ark_key = rnd128(); sr_in = rnd128(); mc_in = rnd128();
      applyStimulus($sformatf("inv_rand%0d", i));
    end
    invSel = 1'b0;
    applyStimulus("inv_back_fwd");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
